// File: rtl/rr_mux_arb_pkg.sv
// rr_mux_arb_pkg: shared types for the round-robin mux arbiter.
package rr_mux_arb_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker, first valid at or after ptr.
module rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic         any,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  // Scan from farthest to nearest so the nearest valid wins.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (valid[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter driving a shared N_REQ:1 valid/ready mux.
// Optional RR_MUX_ARB_BURST_EN adds req_last/out_last; only a last beat rotates.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_W = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_gnt,
  output logic                    busy
`ifdef RR_MUX_ARB_BURST_EN
  ,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    out_last
`endif
);
  state_e state, state_n;
  logic [IDX_W-1:0] gnt, gnt_n, ptr, ptr_n, nxt, pick_ptr, idx;
  logic any, last;
  assign nxt = (gnt == IDX_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
  // In BUSY the only re-pick that matters is after a transfer, from gnt+1.
  assign pick_ptr = (state == BUSY) ? nxt : ptr;
  rr_pick #(.N(N_REQ), .W(IDX_W)) u_pick (
    .valid(req_valid),
    .ptr(pick_ptr),
    .any(any),
    .idx(idx)
  );
  assign busy = state == BUSY;
  assign out_gnt = gnt;
  assign out_valid = busy & req_valid[gnt];
  assign out_data = req_data[int'(gnt)*DATA_W +: DATA_W];
`ifdef RR_MUX_ARB_BURST_EN
  assign out_last = req_last[gnt];
  assign last = out_last;
`else
  assign last = 1'b1;
`endif
  always_comb begin
    req_ready = '0;
    req_ready[gnt] = busy & out_ready;
  end
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    ptr_n = ptr;
    if (state == IDLE) begin
      state_n = any ? BUSY : IDLE;
      gnt_n = any ? idx : gnt;
    end else if (!req_valid[gnt]) begin
      state_n = IDLE;
    end else if (out_ready && last) begin
      ptr_n = nxt;
      state_n = any ? BUSY : IDLE;
      gnt_n = any ? idx : gnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt <= '0;
      ptr <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      ptr <= ptr_n;
    end
  end
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: table-driven scoreboard bench for rr_mux_arbiter.
module tb_rr_mux_arbiter;
  logic clk = 1'b0;
  logic rst, out_ready, out_valid, busy;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_data;
  logic [7:0] out_data;
  logic [1:0] out_gnt;
`ifdef RR_MUX_ARB_BURST_EN
  logic [3:0] req_last;
  logic out_last;
`endif
  typedef struct {
    logic r;
    logic [3:0] v;
    logic rd;
    logic [3:0] l;
    logic ov;
    logic [1:0] g;
    logic [3:0] rr;
    logic bz;
  } vec_t;
  typedef struct {
    logic ov;
    logic [1:0] g;
    logic [3:0] rr;
    logic bz;
    logic [7:0] d;
    logic ol;
  } exp_t;
  vec_t vecs[$];
  exp_t sb[$];
  int num_pass = 0;
  int num_chk = 0;
  rr_mux_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .out_gnt(out_gnt),
    .busy(busy)
`ifdef RR_MUX_ARB_BURST_EN
    ,
    .req_last(req_last),
    .out_last(out_last)
`endif
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, input logic [3:0] v, input logic rd, input logic [3:0] l,
                     input logic ov, input logic [1:0] g, input logic [3:0] rr, input logic bz);
    vecs.push_back('{r, v, rd, l, ov, g, rr, bz});
  endtask
  task automatic chk(input int n, input string name, input logic [31:0] act, input logic [31:0] exp);
    num_chk++;
    if (act !== exp) $display("FAIL row %0d %s: got %0h want %0h", n, name, act, exp);
    else num_pass++;
  endtask
  initial begin
    exp_t e;
    logic [3:0] l;
    rst = 1'b1;
    req_valid = 4'hF;
    out_ready = 1'b1;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
`ifdef RR_MUX_ARB_BURST_EN
    req_last = 4'hF;
`endif
    // reset with all valid, then release
    add(1, 4'hF, 1, 4'hF, 0, 0, 4'b0000, 0);
    add(1, 4'hF, 1, 4'hF, 0, 0, 4'b0000, 0);
    add(0, 4'hF, 0, 4'hF, 0, 0, 4'b0000, 0);
    // full rotation 0,1,2,3,0 without bubbles
    add(0, 4'hF, 1, 4'hF, 1, 0, 4'b0001, 1);
    add(0, 4'hF, 1, 4'hF, 1, 1, 4'b0010, 1);
    add(0, 4'hF, 1, 4'hF, 1, 2, 4'b0100, 1);
    add(0, 4'hF, 1, 4'hF, 1, 3, 4'b1000, 1);
    add(0, 4'hF, 1, 4'hF, 1, 0, 4'b0001, 1);
    // stall on gnt 1 for 5 cycles, then release: next is 2 so ptr held
    for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 4'hF, 1, 1, 4'b0000, 1);
    add(0, 4'hF, 1, 4'hF, 1, 1, 4'b0010, 1);
    // single requester 2 at full rate
    for (int i = 0; i < 3; i++) add(0, 4'b0100, 1, 4'hF, 1, 2, 4'b0100, 1);
    // granted requester drops valid: back to IDLE, ptr stays 3
    add(0, 4'b1001, 0, 4'hF, 0, 2, 4'b0000, 1);
    add(0, 4'b1001, 0, 4'hF, 0, 2, 4'b0000, 0);
    // 3 -> 0 -> 3 -> 0 wrap
    add(0, 4'b1001, 1, 4'hF, 1, 3, 4'b1000, 1);
    add(0, 4'b1001, 1, 4'hF, 1, 0, 4'b0001, 1);
    add(0, 4'b1001, 1, 4'hF, 1, 3, 4'b1000, 1);
    add(0, 4'b0000, 1, 4'hF, 0, 0, 4'b0001, 1);
    add(0, 4'b0000, 1, 4'hF, 0, 0, 4'b0000, 0);
    // reset while a beat is offered: dropped, ptr back to 0
    add(0, 4'b0010, 0, 4'hF, 0, 0, 4'b0000, 0);
    add(1, 4'b0010, 1, 4'hF, 1, 1, 4'b0010, 1);
    add(0, 4'b0010, 1, 4'hF, 0, 0, 4'b0000, 0);
    add(0, 4'b0010, 1, 4'hF, 1, 1, 4'b0010, 1);
`ifdef RR_MUX_ARB_BURST_EN
    // burst of 3 from req 0 while req 1 waits, then reset mid-burst of req 1
    add(1, 4'b0011, 0, 4'hF, 1, 1, 4'b0000, 1);
    add(0, 4'b0011, 0, 4'h0, 0, 0, 4'b0000, 0);
    add(0, 4'b0011, 1, 4'h0, 1, 0, 4'b0001, 1);
    add(0, 4'b0011, 1, 4'h0, 1, 0, 4'b0001, 1);
    add(0, 4'b0011, 1, 4'b0001, 1, 0, 4'b0001, 1);
    add(0, 4'b0011, 1, 4'h0, 1, 1, 4'b0010, 1);
    add(1, 4'b0011, 1, 4'h0, 1, 1, 4'b0010, 1);
    add(0, 4'b0011, 0, 4'h0, 0, 0, 4'b0000, 0);
    add(0, 4'b0011, 0, 4'h0, 1, 0, 4'b0000, 1);
`endif
    @(posedge clk);
    @(negedge clk);
    foreach (vecs[i]) begin
      rst = vecs[i].r;
      req_valid = vecs[i].v;
      out_ready = vecs[i].rd;
      l = vecs[i].l;
`ifdef RR_MUX_ARB_BURST_EN
      req_last = l;
`endif
      sb.push_back('{vecs[i].ov, vecs[i].g, vecs[i].rr, vecs[i].bz, 8'h10 + 8'(vecs[i].g), l[vecs[i].g]});
      #2;
      e = sb.pop_front();
      chk(i, "out_valid", 32'(out_valid), 32'(e.ov));
      chk(i, "out_gnt", 32'(out_gnt), 32'(e.g));
      chk(i, "req_ready", 32'(req_ready), 32'(e.rr));
      chk(i, "busy", 32'(busy), 32'(e.bz));
      chk(i, "out_data", 32'(out_data), 32'(e.d));
`ifdef RR_MUX_ARB_BURST_EN
      chk(i, "out_last", 32'(out_last), 32'(e.ol));
`endif
      @(negedge clk);
    end
    $display("%0d/%0d checks passed", num_pass, num_chk);
    $finish;
  end
endmodule
